// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared alu opcodes, data width and result-slot state type
package alu_pkg;
    localparam int DATA_W = 32;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;
    localparam logic [3:0] ALUC_HMD = 4'b1011;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;
endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 32-bit combinational alu
//   a    : operand a, also the full 32-bit shift amount for shifts
//   b    : operand b, the value being shifted for shifts
//   aluc : opcode (ALUC_* in alu_pkg)
//   s    : result; undefined opcodes give 0
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        aluc,
    output logic [DATA_W-1:0] s
);
    // Shift amounts of 32 or more shift everything out.
    logic big_shift;
    assign big_shift = (a >= 32'd32);

    always_comb begin
        s = '0;
        case (aluc)
            ALUC_ADD: s = a + b;
            ALUC_SUB: s = a - b;
            ALUC_AND: s = a & b;
            ALUC_OR:  s = a | b;
            ALUC_XOR: s = a ^ b;
            ALUC_LUI: s = {b[15:0], 16'h0000};
            ALUC_SLL: s = big_shift ? '0 : (b << a[4:0]);
            ALUC_SRL: s = big_shift ? '0 : (b >> a[4:0]);
            ALUC_SRA: s = big_shift ? {DATA_W{b[DATA_W-1]}}
                                    : $unsigned($signed(b) >>> a[4:0]);
            ALUC_HMD: s = DATA_W'($countones(a ^ b));
            default:  s = '0;
        endcase
    end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with priority pointer
//   clk, clrn : clock, asynchronous active-low reset
//   elig      : bit i set when port i may be granted this cycle
//   grant     : one-hot (or zero) grant, combinational from elig and pointer
module rr_arb2 #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [1:0] elig,
    output logic [1:0] grant
);
    // ptr names the port that wins when both are eligible.
    logic ptr;

    always_comb begin
        grant = elig;
        if (elig == 2'b11) begin
            grant = ptr ? 2'b10 : 2'b01;
        end
    end

    // After any grant, priority passes to the port that did not win.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ptr <= FIRST_PRIO;
        end else if (|grant) begin
            ptr <= grant[0];
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one alu between two valid/ready requesters
//   clk, clrn          : clock, asynchronous active-low reset
//   req_valid/ready[i] : request handshake for port i
//   req_a/b/aluc{0,1}  : operands and opcode of each port
//   rsp_valid/ready[i] : response handshake for port i
//   rsp_s{0,1}         : registered result of each port
module alu_arbiter
    import alu_pkg::*;
#(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [3:0]        req_aluc0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    input  logic [3:0]        req_aluc1,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_s0,
    output logic [DATA_W-1:0] rsp_s1
);
    slot_e             slot_q [2];
    logic [DATA_W-1:0] res_q  [2];
    logic [1:0]        elig;
    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W-1:0] alu_s;

    // A full slot can still accept when its consumer drains it this cycle.
    // Gating with clrn keeps req_ready low throughout reset.
    assign elig[0] = clrn && req_valid[0] && (slot_q[0] == SLOT_EMPTY || rsp_ready[0]);
    assign elig[1] = clrn && req_valid[1] && (slot_q[1] == SLOT_EMPTY || rsp_ready[1]);

    rr_arb2 #(
        .FIRST_PRIO(FIRST_PRIO)
    ) u_arb (
        .clk  (clk),
        .clrn (clrn),
        .elig (elig),
        .grant(grant)
    );

    assign req_ready = grant;

    // Port 0 operands feed the alu whenever port 1 is not granted.
    assign alu_a  = grant[1] ? req_a1    : req_a0;
    assign alu_b  = grant[1] ? req_b1    : req_b0;
    assign alu_op = grant[1] ? req_aluc1 : req_aluc0;

    alu u_alu (
        .a   (alu_a),
        .b   (alu_b),
        .aluc(alu_op),
        .s   (alu_s)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= SLOT_EMPTY;
                res_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i]) begin
                    slot_q[i] <= SLOT_FULL;
                    res_q[i]  <= alu_s;
                end else if (slot_q[i] == SLOT_FULL && rsp_ready[i]) begin
                    slot_q[i] <= SLOT_EMPTY;
                end
            end
        end
    end

    assign rsp_valid[0] = (slot_q[0] == SLOT_FULL);
    assign rsp_valid[1] = (slot_q[1] == SLOT_FULL);
    assign rsp_s0       = res_q[0];
    assign rsp_s1       = res_q[1];
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam bit FP = 1'b0;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
    logic [3:0]  req_aluc0 = '0, req_aluc1 = '0;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [31:0] rsp_s0, rsp_s1;

    always #5 clk = ~clk;

    alu_arbiter #(.FIRST_PRIO(FP)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a0   (req_a0),
        .req_b0   (req_b0),
        .req_aluc0(req_aluc0),
        .req_a1   (req_a1),
        .req_b1   (req_b1),
        .req_aluc1(req_aluc1),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_s0   (rsp_s0),
        .rsp_s1   (rsp_s1)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference alu written bit-by-bit from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        int          src;
        r = '0;
        case (op)
            ALUC_ADD: r = a + b;
            ALUC_SUB: r = a - b;
            ALUC_AND: r = a & b;
            ALUC_OR:  r = a | b;
            ALUC_XOR: r = a ^ b;
            ALUC_LUI: r = b * 32'd65536;
            ALUC_SLL: if (a < 32) for (int i = 0; i < 32; i++) begin
                          src = i - int'(a);
                          r[i] = (src >= 0) ? b[src] : 1'b0;
                      end
            ALUC_SRL: if (a < 32) for (int i = 0; i < 32; i++) begin
                          src = i + int'(a);
                          r[i] = (src < 32) ? b[src] : 1'b0;
                      end
            ALUC_SRA: for (int i = 0; i < 32; i++) begin
                          if (a >= 32) r[i] = b[31];
                          else begin
                              src = i + int'(a);
                              r[i] = (src < 32) ? b[src] : b[31];
                          end
                      end
            ALUC_HMD: for (int i = 0; i < 32; i++) r = r + 32'(a[i] != b[i]);
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Transaction-level model: slot occupancy, held value, last winner,
    // per-port queues of accepted results and eligible-wait counters.
    logic [1:0]  m_full;
    logic [31:0] m_val [2];
    int          m_last;
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          wait_cnt [2];
    logic [1:0]  e, g;

    always @(negedge clk) begin
        if (!clrn) begin
            chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
            chk("reset_req_ready", 32'(req_ready), 32'd0);
            chk("reset_rsp_s0", rsp_s0, 32'd0);
            chk("reset_rsp_s1", rsp_s1, 32'd0);
            m_full = '0;
            m_val[0] = '0;
            m_val[1] = '0;
            m_last = FP ? 0 : 1;
            q0.delete();
            q1.delete();
            wait_cnt[0] = 0;
            wait_cnt[1] = 0;
        end else begin
            for (int i = 0; i < 2; i++) e[i] = req_valid[i] && (!m_full[i] || rsp_ready[i]);
            if (e == 2'b11) g = (m_last == 0) ? 2'b10 : 2'b01;
            else g = e;
            chk("req_ready", 32'(req_ready), 32'(g));
            chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
            chk("rsp_s0", rsp_s0, m_val[0]);
            chk("rsp_s1", rsp_s1, m_val[1]);
            if (m_full[0] && rsp_ready[0]) begin
                if (q0.size() == 0) chk("sb0_spurious", 32'd0, 32'd1);
                else chk("sb0_order", rsp_s0, q0.pop_front());
            end
            if (m_full[1] && rsp_ready[1]) begin
                if (q1.size() == 0) chk("sb1_spurious", 32'd0, 32'd1);
                else chk("sb1_order", rsp_s1, q1.pop_front());
            end
            for (int i = 0; i < 2; i++) begin
                if (g[i]) begin
                    chk("starve_wait", (wait_cnt[i] <= 1) ? 32'd0 : 32'(wait_cnt[i]), 32'd0);
                    wait_cnt[i] = 0;
                end else if (e[i]) wait_cnt[i]++;
                else wait_cnt[i] = 0;
            end
            if (g[0]) begin
                m_full[0] = 1'b1;
                m_val[0] = ref_alu(req_aluc0, req_a0, req_b0);
                q0.push_back(m_val[0]);
            end else if (m_full[0] && rsp_ready[0]) m_full[0] = 1'b0;
            if (g[1]) begin
                m_full[1] = 1'b1;
                m_val[1] = ref_alu(req_aluc1, req_a1, req_b1);
                q1.push_back(m_val[1]);
            end else if (m_full[1] && rsp_ready[1]) m_full[1] = 1'b0;
            if (g != 2'b00) m_last = g[1] ? 1 : 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] ops [12] = '{ALUC_ADD, ALUC_SUB, ALUC_AND, ALUC_OR, ALUC_XOR, ALUC_LUI,
                             ALUC_SLL, ALUC_SRL, ALUC_SRA, ALUC_HMD, 4'b1001, 4'b1110};
    logic [1:0] held;

    function automatic logic [31:0] rand_a();
        return ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    endfunction

    initial begin
        repeat (2) tick();
        chk("lit_reset_valid", 32'(rsp_valid), 32'd0);

        // Both ports every cycle from reset: grants alternate 0,1,0,1.
        clrn = 1'b1;
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        req_a0 = 32'd10; req_b0 = 32'd3; req_aluc0 = ALUC_SUB;
        req_a1 = 32'd4;  req_b1 = 32'h8000_0000; req_aluc1 = ALUC_SRA;
        #1 chk("lit_alt_g0", 32'(req_ready), 32'd1);
        tick();
        chk("lit_sub", rsp_s0, 32'h0000_0007);
        chk("lit_alt_g1", 32'(req_ready), 32'd2);
        tick();
        chk("lit_sra", rsp_s1, 32'hF800_0000);
        chk("lit_alt_g2", 32'(req_ready), 32'd1);
        tick();
        chk("lit_alt_g3", 32'(req_ready), 32'd2);
        tick();

        // Single ADD on port 0.
        req_valid = 2'b01;
        req_a0 = 32'd5; req_b0 = 32'd3; req_aluc0 = ALUC_ADD;
        #1 chk("lit_add_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("lit_add_valid", 32'(rsp_valid[0]), 32'd1);
        chk("lit_add", rsp_s0, 32'h0000_0008);
        tick();

        // Port 1 consumer stalled: its result holds, port 0 keeps flowing.
        rsp_ready = 2'b01;
        req_valid = 2'b10;
        req_b1 = 32'h1234; req_aluc1 = ALUC_LUI;
        #1 chk("lit_lui_ready", 32'(req_ready), 32'd2);
        tick();
        chk("lit_lui", rsp_s1, 32'h1234_0000);
        req_b1 = 32'h5678;
        req_valid = 2'b11;
        req_a0 = 32'd1; req_b0 = 32'd2;
        #1 chk("lit_stall_g", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lit_stall_loop_g", 32'(req_ready), 32'd1);
            chk("lit_stall_hold", rsp_s1, 32'h1234_0000);
        end
        rsp_ready = 2'b11;
        #1 chk("lit_unstall_g", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        chk("lit_lui2", rsp_s1, 32'h5678_0000);

        // Hamming distance, undefined opcode, oversized shifts.
        req_valid = 2'b01;
        req_a0 = 32'hFFFF_0000; req_b0 = 32'h0000_FFFF; req_aluc0 = ALUC_HMD;
        tick();
        chk("lit_hmd", rsp_s0, 32'd32);
        req_aluc0 = 4'b1001;
        tick();
        chk("lit_undef", rsp_s0, 32'd0);
        req_a0 = 32'd100; req_b0 = 32'h8000_0001; req_aluc0 = ALUC_SRA;
        tick();
        chk("lit_sra_big", rsp_s0, 32'hFFFF_FFFF);
        req_a0 = 32'd40; req_aluc0 = ALUC_SLL;
        tick();
        chk("lit_sll_big", rsp_s0, 32'd0);
        req_valid = 2'b00;
        tick();

        // Async reset with a slot full discards it at once.
        rsp_ready = 2'b00;
        req_valid = 2'b01;
        req_a0 = 32'd1; req_b0 = 32'd1; req_aluc0 = ALUC_ADD;
        tick();
        req_valid = 2'b00;
        chk("lit_full_before_rst", 32'(rsp_valid), 32'd1);
        #2;
        req_valid = 2'b11;
        clrn = 1'b0;
        #1;
        chk("lit_async_rst_valid", 32'(rsp_valid), 32'd0);
        chk("lit_async_rst_ready", 32'(req_ready), 32'd0);
        tick();
        clrn = 1'b1;
        rsp_ready = 2'b11;
        req_a0 = 32'd2; req_b0 = 32'd2; req_aluc0 = ALUC_ADD;
        #1 chk("lit_first_prio", 32'(req_ready), 32'd1);
        tick();
        chk("lit_after_rst", rsp_s0, 32'd4);

        // Random traffic; operands held while a request is pending.
        req_valid = 2'b00;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk);
            held = req_valid & ~req_ready;
            tick();
            if (!held[0]) begin
                req_valid[0] = ($urandom_range(0, 3) != 0);
                req_a0 = rand_a();
                req_b0 = $urandom;
                req_aluc0 = ops[$urandom_range(0, 11)];
            end
            if (!held[1]) begin
                req_valid[1] = ($urandom_range(0, 3) != 0);
                req_a1 = rand_a();
                req_b1 = $urandom;
                req_aluc1 = ops[$urandom_range(0, 11)];
            end
            rsp_ready = 2'($urandom_range(0, 3));
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (3) tick();
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the team's 32-bit combinational alu between two independent requesters (port 0, port 1).
- Valid/ready handshake on both the request and response side of each port.
- Round-robin arbitration.
- Per-port registered result buffer, so a stalled consumer never blocks the other port.
- Sits between two issue sources (e.g. two pipeline lanes or a CPU plus a coprocessor) and the shared alu.

Parameters:
FIRST_PRIO, 0, port that holds round-robin priority out of reset (0 or 1)

Ports:
clk  in  1  clock, rising edge
clrn  in  1  asynchronous active-low reset
req_valid  in  2  bit i: port i presents an operation
req_ready  out  2  bit i: port i operation accepted this cycle
req_a0  in  32  port 0 operand a (shift amount for shifts)
req_b0  in  32  port 0 operand b
req_aluc0  in  4  port 0 alu opcode, alu encoding
req_a1  in  32  port 1 operand a
req_b1  in  32  port 1 operand b
req_aluc1  in  4  port 1 alu opcode
rsp_valid  out  2  bit i: result for port i held
rsp_ready  in  2  bit i: port i consumer takes result
rsp_s0  out  32  port 0 result
rsp_s1  out  32  port 1 result

Behaviour:
- Reset (clrn=0, async):
  - rsp_valid=0; rsp_s0=rsp_s1=0.
  - Priority pointer = FIRST_PRIO.
  - req_ready=0 while clrn low.
  - Reset mid-transaction discards held results with no response.
- Slot state per port: EMPTY or FULL (one 32-bit result register per port).
  - EMPTY -> FULL: on grant.
  - FULL -> EMPTY: on rsp_valid && rsp_ready with no same-cycle grant.
  - FULL -> FULL: on drain plus grant in the same cycle; the register is overwritten with the new result.
- Eligibility: port i is eligible when req_valid[i] && (slot i EMPTY || rsp_ready[i]). Same-cycle drain/refill gives full throughput.
- Arbitration (combinational, one grant per cycle):
  - Only one port eligible: it wins.
  - Both eligible: the port named by the priority pointer wins.
  - The pointer moves to the other port after every grant, including single-port grants.
  - No grant: pointer unchanged.
- req_ready[i] = grant[i]. It is combinational from req_valid, rsp_ready, slot state and pointer. It never depends on operands.
- Datapath:
  - The grant mux selects {a,b,aluc} of the winner into the single alu.
  - The alu output s is captured into the winner's result register at the edge where req_valid && req_ready.
  - Latency: accepted at edge N; rsp_valid high and rsp_s valid from just after edge N.
- Operation semantics are exactly the alu's:
  - ADD, SUB, AND, OR, XOR, LUI (b<<16).
  - SLL, SRL, SRA use the full 32-bit a as the shift amount. a>=32 gives 0 (SLL/SRL) or sign fill (SRA).
  - 4'b1011 gives the Hamming distance.
  - Undefined opcodes give 0; no error flag.
- Holding rules:
  - rsp_s and rsp_valid stay stable while rsp_valid && !rsp_ready.
  - Requesters must hold operands stable while req_valid && !req_ready. The arbiter does not check this.
- Idle: with no grant, the alu input mux is driven to port-0 operands. This does not affect state.
- Starvation bound: a continuously eligible port is granted within 2 cycles.

Decomposition:
- Shared package alu_pkg holds:
  - ALUC_* localparam constants: ADD 4'b0000, SUB 4'b0100, AND 4'b0001, OR 4'b0101, XOR 4'b0010, LUI 4'b0110, SLL 4'b0011, SRL 4'b0111, SRA 4'b1111, HMD 4'b1011.
  - Width constant DATA_W=32.
- One natural sub-module: rr_arb2 (2-way round-robin grant plus pointer flop, ~40 lines).
- The existing alu module is instantiated unmodified.
- Result slots and the operand mux stay in alu_arbiter.

Test Plan:
- Reset, then port 0 ADD a=5 b=3, rsp_ready=1 -> req_ready[0]=1 that cycle; next cycle rsp_valid[0]=1, rsp_s0=32'h8.
- Both ports valid every cycle, FIRST_PRIO=0; port 0 SUB 10-3, port 1 SRA a=4 b=32'h80000000; ready held 1 -> grants alternate 0,1,0,1; rsp_s0=32'h7, rsp_s1=32'hF8000000.
- Port 1 LUI b=32'h1234 with rsp_ready[1]=0 -> rsp_s1=32'h12340000 held; second port-1 request stalls (req_ready[1]=0) while port-0 requests keep being granted; raising rsp_ready[1] grants port 1 the same cycle.
- Port 0 HMD a=32'hFFFF0000 b=32'h0000FFFF -> rsp_s0=32'd32; undefined opcode via a spare encoding -> rsp_s0=0.
- Slot full, assert clrn=0 asynchronously mid-cycle -> rsp_valid=2'b00 immediately; after release, FIRST_PRIO port wins the first simultaneous request.
- Random valid/ready on both ports for 10k cycles against a reference model -> every accepted op returns exactly once, in order per port, correct value; no port waits more than 2 eligible cycles.
